aq_axis_djpeg_fbwr: RTL
=======================

AQ_AXIS_DJPEG_FBWR -- requirements
Module: aq_axis_djpeg_fbwr

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: framebuffer byte-address width.
REQ-002 SHALL have port ACLK  input  1: single clock for all logic.
REQ-003 SHALL have port ARESETN  input  1: asynchronous, active-low reset.
REQ-004 SHALL have port ENABLE  input  1: accept pixels while high.
REQ-005 SHALL have port BASE_ADDR  input  ADDR_W: framebuffer base byte address.
REQ-006 SHALL have port STRIDE  input  16: line pitch in bytes.
REQ-007 SHALL have port S_AXIS_TDATA  input  32: pixel {8'd0,R,G,B}.
REQ-008 SHALL have port S_AXIS_TUSER  input  48: {width[15:0], y[15:0], x[15:0]}.
REQ-009 SHALL have port S_AXIS_TLAST  input  1: last pixel of frame.
REQ-010 SHALL have port S_AXIS_TVALID  input  1, and port S_AXIS_TREADY  output  1: input handshake.
REQ-011 SHALL have port M_WADDR  output  ADDR_W: write byte address.
REQ-012 SHALL have port M_WDATA  output  32: write data, TDATA passed unchanged.
REQ-013 SHALL have port M_WLAST  output  1: carries TLAST of the pixel.
REQ-014 SHALL have port M_WVALID  output  1, and port M_WREADY  input  1: output handshake.
REQ-015 SHALL have port FRAME_DONE  output  1: one-cycle pulse per completed frame.
REQ-016 SHALL have port PIXEL_CNT  output  32: pixels written in current frame.
REQ-017 SHALL have port XERR  output  1: sticky flag, x >= width seen.

Function
REQ-018 SHALL compute M_WADDR = base + y*stride + x*4, truncated modulo 2^ADDR_W.
- y*stride: 16x16 unsigned, 32-bit product.
REQ-019 SHALL implement a two-stage pipeline.
- S1 registers y*stride, x*4, data, last.
- S2 registers the sum onto M_WADDR/M_WDATA/M_WLAST/M_WVALID.
- Latency: exactly 2 cycles from input handshake to M_WVALID when unstalled.
REQ-020 SHALL advance the pipeline when adv = ~M_WVALID | M_WREADY; no stage changes when adv is low.
REQ-021 SHALL drive S_AXIS_TREADY = ENABLE & adv.
- Throughput: one pixel per cycle under continuous M_WREADY.
REQ-022 SHALL hold M_WADDR, M_WDATA and M_WLAST stable while M_WVALID & ~M_WREADY.
REQ-023 SHALL latch BASE_ADDR and STRIDE on the first accepted pixel of each frame.
- First pixel = first handshake after reset or after a TLAST handshake.
- The latched values apply to every pixel of that frame, including the first.
- Changes mid-frame are ignored.
REQ-024 SHALL manage PIXEL_CNT on output handshakes.
- Increment on each M_WVALID & M_WREADY.
- Reset to 1 on the first handshake after a frame's M_WLAST handshake.
- Wraps at 2^32.
REQ-025 SHALL pulse FRAME_DONE high for one cycle, the cycle after the M_WLAST handshake.
REQ-026 SHALL set XERR when an accepted pixel has x >= width; the pixel is still written; XERR clears only on reset.
REQ-027 SHALL, when ENABLE falls mid-frame, stop accepting input while in-flight pixels drain normally; the frame state is retained.
REQ-028 SHALL require no state machine beyond pipeline valids and a first-pixel flag.

Reset
REQ-029 SHALL clear all registers asynchronously on ARESETN low.
- M_WVALID=0, M_WADDR=0, M_WDATA=0, M_WLAST=0.
- FRAME_DONE=0, PIXEL_CNT=0, XERR=0, first-pixel flag=1.
REQ-030 SHALL discard in-flight pixels on reset mid-frame, with no spurious handshake after release.

Structure
REQ-031 SHALL place in a shared package:
- TUSER field offsets X_LSB=0, Y_LSB=16, W_LSB=32.
- BYTES_PER_PIXEL=4.
REQ-032 SHALL be a single module with no sub-modules; the 16x16 multiplier SHALL be inferred.

Verification
REQ-033 SHALL cover basic address generation: base=0x1000_0000, stride=2560, pixel x=3 y=2 -> M_WADDR=0x1000_140C 2 cycles after accept.
REQ-034 SHALL cover backpressure: M_WREADY low 5 cycles during a 10-pixel burst -> TREADY low, outputs stable, all 10 pixels delivered in order without loss.
REQ-035 SHALL cover mid-frame config change: BASE_ADDR changed after pixel 1 -> frame still uses the old base; the next frame uses the new base.
REQ-036 SHALL cover frame end: 8x8 frame, TLAST on pixel 64 -> M_WLAST on 64th write, FRAME_DONE single pulse, PIXEL_CNT=64, then 1 on next frame's first write.
REQ-037 SHALL cover the x-bound error: x=16 width=16 -> XERR=1 and the write still issued; ARESETN low mid-frame -> M_WVALID=0 immediately, XERR=0.
REQ-038 SHALL cover address wrap: base=0xFFFF_FFF0, x=8 y=0 -> M_WADDR=0x0000_0010.

Source files
------------

// File: rtl/aq_axis_djpeg_fbwr_pkg.sv
// Shared TUSER field layout, pixel geometry and address-offset helpers
// for the DJPEG framebuffer writer.
package aq_axis_djpeg_fbwr_pkg;

  localparam int unsigned COORD_W         = 16;
  localparam int unsigned X_LSB           = 0;
  localparam int unsigned Y_LSB           = 16;
  localparam int unsigned W_LSB           = 32;
  localparam int unsigned BYTES_PER_PIXEL = 4;
  localparam int unsigned XOFF_W          = COORD_W + 2;
  localparam int unsigned PROD_W          = 2 * COORD_W;

  function automatic logic [XOFF_W-1:0] pixel_offset(input logic [COORD_W-1:0] x);
    return XOFF_W'(x) * XOFF_W'(BYTES_PER_PIXEL);
  endfunction

  function automatic logic [PROD_W-1:0] line_offset(input logic [COORD_W-1:0] y,
                                                     input logic [COORD_W-1:0] pitch);
    return PROD_W'(y) * PROD_W'(pitch);
  endfunction

endpackage

// File: rtl/aq_axis_djpeg_fbwr.sv
// AXI-Stream pixel to framebuffer write converter: two-stage address pipeline
// (line/pixel offsets, then base add) with per-frame latched base and stride.
module aq_axis_djpeg_fbwr
  import aq_axis_djpeg_fbwr_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              ENABLE,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [15:0]       STRIDE,
  input  logic [31:0]       S_AXIS_TDATA,
  input  logic [47:0]       S_AXIS_TUSER,
  input  logic              S_AXIS_TLAST,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  output logic [ADDR_W-1:0] M_WADDR,
  output logic [31:0]       M_WDATA,
  output logic              M_WLAST,
  output logic              M_WVALID,
  input  logic              M_WREADY,
  output logic              FRAME_DONE,
  output logic [31:0]       PIXEL_CNT,
  output logic              XERR
);

  logic               adv;
  logic               in_hs;
  logic               out_hs;
  logic [COORD_W-1:0] px_x;
  logic [COORD_W-1:0] px_y;
  logic [COORD_W-1:0] px_w;
  logic [ADDR_W-1:0]  base_eff;
  logic [15:0]        stride_eff;

  logic               first_px;
  logic [ADDR_W-1:0]  base_q;
  logic [15:0]        stride_q;
  logic               cnt_restart;

  logic               s1_valid;
  logic [PROD_W-1:0]  s1_prod;
  logic [XOFF_W-1:0]  s1_xoff;
  logic [ADDR_W-1:0]  s1_base;
  logic [31:0]        s1_data;
  logic               s1_last;

  always_comb begin
    adv           = ~M_WVALID | M_WREADY;
    S_AXIS_TREADY = ENABLE & adv;
    in_hs         = S_AXIS_TVALID & S_AXIS_TREADY;
    out_hs        = M_WVALID & M_WREADY;
    px_x          = S_AXIS_TUSER[X_LSB +: COORD_W];
    px_y          = S_AXIS_TUSER[Y_LSB +: COORD_W];
    px_w          = S_AXIS_TUSER[W_LSB +: COORD_W];
    // The first pixel of a frame must already use the values it latches.
    base_eff      = first_px ? BASE_ADDR : base_q;
    stride_eff    = first_px ? STRIDE    : stride_q;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      first_px <= 1'b1;
      base_q   <= '0;
      stride_q <= '0;
      XERR     <= 1'b0;
    end else if (in_hs) begin
      if (first_px) begin
        base_q   <= BASE_ADDR;
        stride_q <= STRIDE;
      end
      first_px <= S_AXIS_TLAST;
      if (px_x >= px_w) XERR <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_xoff  <= '0;
      s1_base  <= '0;
      s1_data  <= '0;
      s1_last  <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_hs;
      if (in_hs) begin
        s1_prod <= line_offset(px_y, stride_eff);
        s1_xoff <= pixel_offset(px_x);
        s1_base <= base_eff;
        s1_data <= S_AXIS_TDATA;
        s1_last <= S_AXIS_TLAST;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      M_WVALID <= 1'b0;
      M_WADDR  <= '0;
      M_WDATA  <= '0;
      M_WLAST  <= 1'b0;
    end else if (adv) begin
      M_WVALID <= s1_valid;
      if (s1_valid) begin
        M_WADDR <= s1_base + ADDR_W'(s1_prod) + ADDR_W'(s1_xoff);
        M_WDATA <= s1_data;
        M_WLAST <= s1_last;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      FRAME_DONE  <= 1'b0;
      PIXEL_CNT   <= '0;
      cnt_restart <= 1'b0;
    end else begin
      FRAME_DONE <= out_hs & M_WLAST;
      if (out_hs) begin
        PIXEL_CNT   <= cnt_restart ? 32'd1 : PIXEL_CNT + 32'd1;
        cnt_restart <= M_WLAST;
      end
    end
  end

endmodule
